tensor_core_scheduler: RTL and testbench
========================================

Name: tensor_core_scheduler

Overview:
- Round-robin scheduler that shares one small_tensor_core between NUM_REQUESTERS clients.
- Per accepted command, in order:
  - selects that client's operand matrices through the external operand mux;
  - pulses the core's register-file write enable, then its start input;
  - waits the core's fixed latency;
  - returns a tagged result-valid handshake.
- Sits between the request-side command logic and the tensor core / operand register file.

Parameters:
- NUM_REQUESTERS, 4, number of clients (2..8).
- ID_WIDTH, $clog2(NUM_REQUESTERS), width of requester index.
- CORE_LATENCY, 2, clock cycles from start pulse until core output is stable (>=1).

Ports:
- clock_in  input  1  single clock, all state on posedge.
- reset_in  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQUESTERS  per-client command valid.
- req_op  input  2*NUM_REQUESTERS  per-client operation: 00 matmul, 01 add, 10 relu, 11 illegal; client i at bits [2i+1:2i].
- req_ready  output  NUM_REQUESTERS  one-hot accept pulse; command taken when valid&ready.
- core_operand_select  output  ID_WIDTH  drives the operand mux to the granted client.
- core_write_enable  output  1  to tensor_core_register_file_write_enable.
- core_start  output  1  to should_start_tensor_core.
- core_operation_select  output  2  to operation_select.
- result_valid  output  1  core output valid for result_id.
- result_id  output  ID_WIDTH  owning client.
- result_error  output  1  set with result_valid for an illegal op.
- result_ready  input  1  consumer accepts result.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE, rr_pointer=0; all outputs 0.
- State IDLE:
  - If any req_valid, grant the first valid client searching from rr_pointer upward with wrap.
  - req_ready[grant]=1 for exactly this one cycle.
  - Latch op and id; drive core_operand_select=id from the next cycle until leaving RESULT.
  - Next state is LOAD, or RESULT with error=1 if op==11.
  - With no req_valid, stay in IDLE; req_ready=0.
- State LOAD (1 cycle): core_write_enable=1 (clears the core counter) -> START.
- State START (1 cycle):
  - core_start=1; core_operation_select=latched op.
  - core_operation_select holds that value through WAIT; it is 0 elsewhere.
  - -> WAIT.
- State WAIT:
  - Down-counter loaded with CORE_LATENCY-1 on entry.
  - Exit to RESULT in the cycle after it reads 0, i.e. WAIT lasts exactly CORE_LATENCY cycles.
- State RESULT:
  - result_valid=1, result_id=id, result_error as latched; held stable until result_ready.
  - Cycle with result_valid & result_ready -> IDLE, rr_pointer=(id+1) mod NUM_REQUESTERS.
- Latency: accept cycle T; core_write_enable T+1; core_start T+2; earliest result_valid T+3+CORE_LATENCY. Illegal op: result_valid T+1, no core pulses.
- Back-to-back: the next grant occurs at the earliest in the IDLE cycle after the result handshake. Only one command is in flight.
- req_valid sampled only in IDLE. Dropping req_valid in other states has no effect. A client must not change req_op while valid and not yet ready.
- core_write_enable and core_start are never high in the same cycle.
- Reset asserted mid-operation returns everything to reset values immediately. The in-flight command is discarded with no result.
- Wrap-around: rr_pointer = NUM_REQUESTERS-1 after a grant to the last client wraps to 0.

Optional Feature:
- Macro: TENSOR_CORE_SCHEDULER_PERF_EN.
- When defined, adds outputs:
  - perf_ops_done (32-bit): increments on each result handshake with error=0.
  - perf_busy_cycles (32-bit): increments every cycle busy=1.
  - perf_errors (16-bit): increments on each error handshake.
- All three counters saturate at max value and reset to 0.
- When undefined, these ports and their logic are absent; no other behaviour changes.

Test Plan:
- Single matmul:
  - Stimulus: reset, then client 2 req_op=00 with result_ready=1, CORE_LATENCY=2.
  - Response: req_ready=0100 at T; write_enable at T+1; start at T+2 with op=00; result_valid at T+5, id=2, error=0; busy low at T+6.
- Contention:
  - Stimulus: all four clients valid continuously from reset.
  - Response: grant order 0,1,2,3,0; each result_id matches its grant.
- Illegal op:
  - Stimulus: client 1 op=11.
  - Response: result_valid at T+1, error=1, id=1; core_write_enable and core_start never pulse.
- Backpressure:
  - Stimulus: result_ready held 0 for 5 cycles in RESULT.
  - Response: result_valid, id, error and operand_select stay stable; no new req_ready until 1 cycle after handshake.
- Reset mid-WAIT:
  - Stimulus: assert reset_in asynchronously during WAIT, release, then client 3 valid.
  - Response: outputs 0 immediately, no result_valid for the aborted command; client 3 granted first (rr_pointer=0 but only 3 valid).
- Perf (macro defined):
  - Stimulus: two good ops and one illegal op.
  - Response: perf_ops_done=2, perf_errors=1, perf_busy_cycles equals the counted busy cycles.

Source files
------------

// File: rtl/tensor_core_scheduler.sv
// Round-robin scheduler sharing one tensor core: accept T, result T+3+CORE_LATENCY (T+1 for illegal op),
// result held until result_ready. Optional perf counters: TENSOR_CORE_SCHEDULER_PERF_EN.
module tensor_core_scheduler #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS),
  parameter int CORE_LATENCY   = 2
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic [NUM_REQUESTERS-1:0]   req_valid,
  input  logic [2*NUM_REQUESTERS-1:0] req_op,
  output logic [NUM_REQUESTERS-1:0]   req_ready,
  output logic [ID_WIDTH-1:0]         core_operand_select,
  output logic                        core_write_enable,
  output logic                        core_start,
  output logic [1:0]                  core_operation_select,
  output logic                        result_valid,
  output logic [ID_WIDTH-1:0]         result_id,
  output logic                        result_error,
  input  logic                        result_ready,
  output logic                        busy
`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
  ,
  output logic [31:0]                 perf_ops_done,
  output logic [31:0]                 perf_busy_cycles,
  output logic [15:0]                 perf_errors
`endif
);

  localparam int CNT_W = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESULT} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] rr_pointer, id_q, grant_id;
  logic [1:0]          op_q, grant_op;
  logic                err_q, grant_found, handshake;
  logic [CNT_W-1:0]    wait_cnt;

  // First valid client at or above rr_pointer, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      idx = int'(rr_pointer) + i;
      if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_WIDTH'(idx);
      end
    end
  end

  assign grant_op = req_op[2*int'(grant_id) +: 2];

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_id] = 1'b1;
          state_nxt = (grant_op == 2'b11) ? RESULT : LOAD;
        end
      end
      LOAD:    state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = RESULT;
      RESULT:  if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign handshake = (state == RESULT) && result_ready;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= IDLE;
      rr_pointer <= '0;
      id_q       <= '0;
      op_q       <= 2'b00;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_found) begin
        id_q  <= grant_id;
        op_q  <= grant_op;
        err_q <= (grant_op == 2'b11);
      end
      if (state == START)
        wait_cnt <= CNT_W'(CORE_LATENCY - 1);
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      if (handshake)
        rr_pointer <= (int'(id_q) == NUM_REQUESTERS - 1) ? '0 : id_q + 1'b1;
    end
  end

  assign busy                  = (state != IDLE);
  assign core_operand_select   = busy ? id_q : '0;
  assign core_write_enable     = (state == LOAD);
  assign core_start            = (state == START);
  assign core_operation_select = (state == START || state == WAIT) ? op_q : 2'b00;
  assign result_valid          = (state == RESULT);
  assign result_id             = result_valid ? id_q : '0;
  assign result_error          = result_valid && err_q;

`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
  // Saturating counters.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      perf_ops_done    <= '0;
      perf_busy_cycles <= '0;
      perf_errors      <= '0;
    end else begin
      if (handshake && !err_q && perf_ops_done != '1)
        perf_ops_done <= perf_ops_done + 32'd1;
      if (handshake && err_q && perf_errors != '1)
        perf_errors <= perf_errors + 16'd1;
      if (busy && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Directed + randomized bench for tensor_core_scheduler against a transaction-level timeline model.
module tb_tensor_core_scheduler;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int L   = 2;

  logic           clk = 1'b0;
  logic           reset_in;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [N-1:0]   req_ready;
  logic [IDW-1:0] core_operand_select;
  logic           core_write_enable;
  logic           core_start;
  logic [1:0]     core_operation_select;
  logic           result_valid;
  logic [IDW-1:0] result_id;
  logic           result_error;
  logic           result_ready;
  logic           busy;
`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
  logic [31:0]    perf_ops_done, perf_busy_cycles;
  logic [15:0]    perf_errors;
`endif

  tensor_core_scheduler #(.NUM_REQUESTERS(N), .ID_WIDTH(IDW), .CORE_LATENCY(L)) dut (
    .clock_in(clk), .reset_in(reset_in), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .core_operand_select(core_operand_select),
    .core_write_enable(core_write_enable), .core_start(core_start),
    .core_operation_select(core_operation_select), .result_valid(result_valid),
    .result_id(result_id), .result_error(result_error), .result_ready(result_ready),
    .busy(busy)
`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
    , .perf_ops_done(perf_ops_done), .perf_busy_cycles(perf_busy_cycles),
    .perf_errors(perf_errors)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr      = 0;
  int m_busy   = 0;
  int m_done   = 0;
  int m_err    = 0;
  int grants[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic rv, input int id, input logic err,
                             input logic we, input logic st, input logic [1:0] cop,
                             input int osel, input logic bz, input logic [N-1:0] rdy);
    check({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
    check({tag, ".result_id"}, 32'(result_id), 32'(id));
    check({tag, ".result_error"}, 32'(result_error), 32'(err));
    check({tag, ".write_enable"}, 32'(core_write_enable), 32'(we));
    check({tag, ".start"}, 32'(core_start), 32'(st));
    check({tag, ".op_select"}, 32'(core_operation_select), 32'(cop));
    check({tag, ".operand_select"}, 32'(core_operand_select), 32'(osel));
    check({tag, ".busy"}, 32'(busy), 32'(bz));
    check({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int model_grant(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic noise(input bit en, input logic [N-1:0] mask);
    req_valid = en ? N'($urandom) : mask;
  endtask

  task automatic model_reset();
    ptr = 0; m_busy = 0; m_done = 0; m_err = 0;
  endtask

  task automatic idle_cycle(input string tag);
    req_valid = '0;
    #1;
    expect_outs(tag, 0, 0, 0, 0, 0, 2'b00, 0, 0, '0);
    step();
  endtask

  // One command from accept to result handshake, checked cycle by cycle.
  task automatic run_txn(input string tag, input logic [N-1:0] mask, input logic [2*N-1:0] ops,
                         input int delay, input bit nz);
    int g;
    logic [1:0] op;
    logic err;
    g   = model_grant(mask);
    op  = ops[2*g +: 2];
    err = (op == 2'b11);
    grants.push_back(g);
    req_valid = mask; req_op = ops; result_ready = 1'b0;
    #1;
    expect_outs({tag, ".accept"}, 0, 0, 0, 0, 0, 2'b00, 0, 0, N'(1 << g));
    step();
    if (!err) begin
      noise(nz, mask); #1;
      expect_outs({tag, ".load"}, 0, 0, 0, 1, 0, 2'b00, g, 1, '0);
      step();
      noise(nz, mask); #1;
      expect_outs({tag, ".start"}, 0, 0, 0, 0, 1, op, g, 1, '0);
      step();
      for (int i = 0; i < L; i++) begin
        noise(nz, mask); #1;
        expect_outs({tag, ".wait"}, 0, 0, 0, 0, 0, op, g, 1, '0);
        step();
      end
      m_busy += 2 + L;
    end
    for (int i = 0; i <= delay; i++) begin
      noise(nz, mask);
      result_ready = (i == delay);
      #1;
      expect_outs({tag, ".result"}, 1, g, err, 0, 0, 2'b00, g, 1, '0);
      step();
    end
    m_busy += delay + 1;
    result_ready = 1'b0;
    req_valid = '0;
    ptr = (g + 1) % N;
    if (err) m_err++; else m_done++;
  endtask

  initial begin
    logic [2*N-1:0] ops;
    reset_in = 1'b1; req_valid = '0; req_op = '0; result_ready = 1'b0;
    #3;
    expect_outs("reset", 0, 0, 0, 0, 0, 2'b00, 0, 0, '0);
    step(); step();
    reset_in = 1'b0;
    model_reset();
`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
    check("perf_reset.ops", perf_ops_done, 0);
    check("perf_reset.busy", perf_busy_cycles, 0);
    check("perf_reset.err", 32'(perf_errors), 0);
`endif
    idle_cycle("idle0");

    // Single matmul from client 2.
    run_txn("matmul", 4'b0100, 8'h00, 0, 1'b0);
    idle_cycle("matmul_done");

    // Contention: all valid from reset, legal random ops; expect 0,1,2,3,0.
    reset_in = 1'b1; step(); reset_in = 1'b0; model_reset();
    grants.delete();
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < N; c++) ops[2*c +: 2] = 2'($urandom_range(0, 2));
      run_txn("contend", 4'b1111, ops, 0, 1'b0);
    end
    for (int t = 0; t < 5; t++) check("contend.order", 32'(grants[t]), 32'(t % N));

    // Illegal op from client 1.
    run_txn("illegal", 4'b0010, 8'b11_11_11_11, 0, 1'b0);
    idle_cycle("illegal_done");

    // Backpressure: result_ready low for 5 cycles.
    run_txn("bp", 4'b0001, 8'($urandom) & 8'h22, 5, 1'b1);
    idle_cycle("bp_done");

    // Reset during WAIT.
    reset_in = 1'b1; step(); reset_in = 1'b0; model_reset();
    req_valid = 4'b0001; req_op = 8'h00;
    step(); req_valid = '0; step(); step();
    #1;
    expect_outs("pre_abort.wait", 0, 0, 0, 0, 0, 2'b00, 0, 1, '0);
    reset_in = 1'b1;
    #1;
    expect_outs("abort.async", 0, 0, 0, 0, 0, 2'b00, 0, 0, '0);
    step();
    #1;
    expect_outs("abort.held", 0, 0, 0, 0, 0, 2'b00, 0, 0, '0);
    reset_in = 1'b0;
    model_reset();
    step();
    idle_cycle("abort_idle");
    run_txn("after_abort", 4'b1000, 8'h00, 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 25; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) idle_cycle("rand_idle");
      run_txn("rand", N'($urandom_range(1, 15)), 8'($urandom), $urandom_range(0, 3), 1'b1);
    end
    idle_cycle("rand_done");

`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
    check("perf.ops_done", perf_ops_done, 32'(m_done));
    check("perf.errors", 32'(perf_errors), 32'(m_err));
    check("perf.busy_cycles", perf_busy_cycles, 32'(m_busy));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
